// File: rtl/timer_pkg.sv
// Shared constants for the timer compare/interrupt block: FSM state codes,
// read-select encodings and the compare register reset value.
package timer_pkg;

  localparam logic [1:0] ST_ARMED  = 2'd0;
  localparam logic [1:0] ST_UPDATE = 2'd1;
  localparam logic [1:0] ST_FIRED  = 2'd2;

  localparam logic [1:0] RD_CNT_LO = 2'd0;
  localparam logic [1:0] RD_CNT_HI = 2'd1;
  localparam logic [1:0] RD_CMP_LO = 2'd2;
  localparam logic [1:0] RD_CMP_HI = 2'd3;

  localparam logic [63:0] CMP_RST_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/timer_rd_snap.sv
// Registered 32-bit read path for counter and compare. A counter-low read
// snapshots the counter high half so a following high read is coherent.
module timer_rd_snap
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] counter,
  input  logic [63:0] compare,
  input  logic        rd_en,
  input  logic [1:0]  rd_sel,
  output logic [31:0] rd_data,
  output logic        rd_valid
);

  logic [31:0] shadow_q, shadow_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  always_comb begin
    shadow_d   = shadow_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    if (rd_en) begin
      case (rd_sel)
        RD_CNT_LO: begin
          rd_data_d = counter[31:0];
          shadow_d  = counter[63:32];
        end
        RD_CNT_HI: rd_data_d = shadow_q;
        RD_CMP_LO: rd_data_d = compare[31:0];
        default:   rd_data_d = compare[63:32];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= 32'd0;
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/timer_cmp_irq.sv
// Compare register, match FSM and sticky interrupt for the 64-bit timer,
// plus the coherent counter/compare read path.
module timer_cmp_irq
  import timer_pkg::*;
#(
  parameter logic [63:0] CMP_RST = CMP_RST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] counter,
  input  logic        timer_en,
  input  logic [31:0] wr_data,
  input  logic        tcmp0_wr_en,
  input  logic        tcmp1_wr_en,
  input  logic        int_en,
  input  logic        int_clr,
  input  logic        rd_en,
  input  logic [1:0]  rd_sel,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [63:0] compare,
  output logic        int_pending,
  output logic        timer_int
);

  logic [1:0]  state_q, state_d;
  logic [31:0] staging_q, staging_d;
  logic [63:0] compare_q, compare_d;
  logic        pending_q, pending_d;
  logic        match;

  // Writes outrank matching; staging always mirrors the committed low half
  // after a commit, so a lone tcmp1 write keeps the existing low word.
  always_comb begin
    state_d   = state_q;
    staging_d = staging_q;
    compare_d = compare_q;
    match     = 1'b0;
    if (tcmp0_wr_en && tcmp1_wr_en) begin
      compare_d = {wr_data, wr_data};
      staging_d = wr_data;
      state_d   = ST_ARMED;
    end else if (tcmp0_wr_en) begin
      staging_d = wr_data;
      state_d   = ST_UPDATE;
    end else if (tcmp1_wr_en) begin
      compare_d = {wr_data, staging_q};
      state_d   = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (timer_en && (counter >= compare_q)) begin
            match   = 1'b1;
            state_d = ST_FIRED;
          end
        end
        ST_UPDATE, ST_FIRED: state_d = state_q;
        default:             state_d = ST_ARMED;
      endcase
    end
    pending_d = match | (pending_q & ~int_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ARMED;
      staging_q <= CMP_RST[31:0];
      compare_q <= CMP_RST;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      staging_q <= staging_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
    end
  end

  assign compare     = compare_q;
  assign int_pending = pending_q;
  assign timer_int   = pending_q & int_en;

  timer_rd_snap u_rd_snap (
    .clk      (clk),
    .rst      (rst),
    .counter  (counter),
    .compare  (compare_q),
    .rd_en    (rd_en),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

endmodule
